bias_add_seq: RTL

- Per-tile sequencer for the lane-wise bias-add stage between the systolic array output and the activation/writeback path.
- On `start` it does three things in order:
  1. Fetches one packed bias word.
  2. Streams a programmed number of 64-bit result rows through the lane-wise add, with a registered, backpressure-safe output stage.
  3. Flags `out_last` on the final row and pulses `tile_done`.
- One tile is in flight at a time.

---
 rtl/bias_add_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bias_add_seq.sv
// Per-tile bias-add sequencer: fetches one packed bias word, then streams a programmed
// number of rows through a lane-wise modular add into a registered, stallable output stage.
module bias_add_seq #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned LANE_W   = 8,
  parameter int unsigned MAX_ROWS = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_rows,
  output logic                    busy,
  input  logic                    bias_valid,
  output logic                    bias_ready,
  input  logic [LANES*LANE_W-1:0] bias_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_last,
  output logic                    tile_done
);

  localparam int unsigned DataW = LANES * LANE_W;
  localparam logic [CNT_W-1:0] MaxRows = CNT_W'(MAX_ROWS);

  typedef enum logic [1:0] {StIdle, StLoadBias, StStream, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rows_q, rows_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [DataW-1:0]   bias_q, bias_d;
  logic [DataW-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [DataW-1:0]   sum;
  logic               in_xfer;
  logic               out_xfer;

  // Each lane wraps independently; no carry crosses a lane boundary.
  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sum[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W] + bias_q[i*LANE_W +: LANE_W];
    end
  end

  // The output register can take a new row in the same cycle it hands one off.
  assign in_ready   = (state_q == StStream) && (acc_cnt_q < rows_q) &&
                      (!out_valid_q || out_ready);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid_q && out_ready;

  assign busy       = (state_q != StIdle);
  assign bias_ready = (state_q == StLoadBias);
  assign tile_done  = (state_q == StDone);
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    acc_cnt_d   = acc_cnt_q;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d    = ((num_rows == '0) || (num_rows > MaxRows)) ? MaxRows : num_rows;
          acc_cnt_d = '0;
          state_d   = StLoadBias;
        end
      end
      StLoadBias: begin
        if (bias_valid) begin
          bias_d  = bias_data;
          state_d = StStream;
        end
      end
      StStream: begin
        if (in_xfer) begin
          out_data_d  = sum;
          out_valid_d = 1'b1;
          out_last_d  = ((acc_cnt_q + CNT_W'(1)) == rows_q);
          acc_cnt_d   = acc_cnt_q + CNT_W'(1);
        end else if (out_xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (out_xfer && out_last_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rows_q      <= '0;
      acc_cnt_q   <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      acc_cnt_q   <= acc_cnt_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
